// File: rtl/grf_write_buffer.sv
// In-order GRF write-back queue with youngest-match bypass lookup.
// Optional trace output enabled by defining GRF_WB_TRACE_EN.

module grf_wb_cmp (
  input  logic       vld,
  input  logic [4:0] a3,
  input  logic [4:0] q,
  output logic       hit
);
  assign hit = vld & (q != 5'd0) & (a3 == q);
endmodule

module grf_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_A3,
  input  logic [31:0]              in_WD,
  input  logic [31:0]              in_PC,
  input  logic                     hold,
  input  logic                     flush,
  output logic [4:0]               A3,
  output logic [31:0]              WD,
  output logic [31:0]              PC,
  output logic                     WE,
  input  logic [4:0]               Q1,
  input  logic [4:0]               Q2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [31:0]              hit1_data,
  output logic [31:0]              hit2_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wreq_t;

  wreq_t           mem [DEPTH];
  wreq_t           hd;
  logic [AW:0]     head, tail;
  logic            full, empty, push, pop;

  assign count    = tail - head;
  assign empty    = (head == tail);
  assign full     = (head[AW-1:0] == tail[AW-1:0]) & (head[AW] != tail[AW]);
  assign in_ready = !full & !flush & reset;
  // $0 writes are accepted but never occupy an entry.
  assign push     = in_valid & in_ready & (in_A3 != 5'd0);
  assign WE       = !empty & !hold;
  assign pop      = WE;

  assign hd = mem[head[AW-1:0]];
  assign A3 = empty ? 5'd0  : hd.a3;
  assign WD = empty ? 32'd0 : hd.wd;
  assign PC = empty ? 32'd0 : hd.pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (pop)  head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail[AW-1:0]] <= '{a3: in_A3, wd: in_WD, pc: in_PC};
  end

  // Per-slot occupancy and address match, then age-ordered youngest pick.
  logic [DEPTH-1:0][AW-1:0] slot_off;
  logic [DEPTH-1:0]         slot_vld, m1, m2;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign slot_off[g] = AW'(g) - head[AW-1:0];
    assign slot_vld[g] = {1'b0, slot_off[g]} < count;
    grf_wb_cmp u_c1 (.vld(slot_vld[g]), .a3(mem[g].a3), .q(Q1), .hit(m1[g]));
    grf_wb_cmp u_c2 (.vld(slot_vld[g]), .a3(mem[g].a3), .q(Q2), .hit(m2[g]));
  end

  logic [AW-1:0] idx;
  always_comb begin
    hit1      = 1'b0;
    hit2      = 1'b0;
    hit1_data = 32'd0;
    hit2_data = 32'd0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head[AW-1:0] + AW'(i);
      if (m1[idx]) begin
        hit1      = 1'b1;
        hit1_data = mem[idx].wd;
      end
      if (m2[idx]) begin
        hit2      = 1'b1;
        hit2_data = mem[idx].wd;
      end
    end
  end

`ifdef GRF_WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (WE) $display("@%h: $%d <= %h", PC, A3, WD);
  end
`else
`endif

endmodule

// File: tb/tb_grf_write_buffer.sv
// Directed + random bench for grf_write_buffer against a queue-based model.
module tb_grf_write_buffer;
  localparam int DEPTH = 4;

  logic        clk = 0, reset, in_valid, hold, flush, WE, in_ready, hit1, hit2;
  logic [4:0]  in_A3, A3, Q1, Q2;
  logic [31:0] in_WD, in_PC, WD, PC, hit1_data, hit2_data;
  logic [2:0]  count;

  grf_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_A3(in_A3), .in_WD(in_WD), .in_PC(in_PC), .hold(hold), .flush(flush),
    .A3(A3), .WD(WD), .PC(PC), .WE(WE), .Q1(Q1), .Q2(Q2),
    .hit1(hit1), .hit2(hit2), .hit1_data(hit1_data), .hit2_data(hit2_data),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   n_assert = 0, n_fail = 0, wcount = 0;
  logic exp_we, exp_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic        h1, h2;
    logic [31:0] d1, d2;
    if (!reset) q.delete();
    exp_rdy = reset && (q.size() < DEPTH) && !flush;
    exp_we  = (q.size() > 0) && !hold;
    h1 = 0; h2 = 0; d1 = 0; d2 = 0;
    foreach (q[i]) begin
      if (Q1 != 0 && q[i].a3 == Q1) begin h1 = 1; d1 = q[i].wd; end
      if (Q2 != 0 && q[i].a3 == Q2) begin h2 = 1; d2 = q[i].wd; end
    end
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("WE", {31'd0, WE}, {31'd0, exp_we});
    chk("count", {29'd0, count}, q.size());
    chk("A3", {27'd0, A3}, q.size() ? {27'd0, q[0].a3} : 32'd0);
    chk("WD", WD, q.size() ? q[0].wd : 32'd0);
    chk("PC", PC, q.size() ? q[0].pc : 32'd0);
    chk("hit1", {31'd0, hit1}, {31'd0, h1});
    chk("hit1_data", hit1_data, d1);
    chk("hit2", {31'd0, hit2}, {31'd0, h2});
    chk("hit2_data", hit2_data, d2);
  endtask

  // Check, advance one edge, update model from the pre-edge decisions.
  task automatic cyc();
    #1;
    check_outputs();
    @(posedge clk);
    if (!reset || flush) q.delete();
    else begin
      if (exp_we) begin void'(q.pop_front()); wcount++; end
      if (in_valid && exp_rdy && in_A3 != 0) q.push_back('{in_A3, in_WD, in_PC});
    end
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] a, input logic [31:0] d,
                     input logic [31:0] p, input logic h, input logic f);
    in_valid = v; in_A3 = a; in_WD = d; in_PC = p; hold = h; flush = f;
  endtask

  initial begin
    int w0;
    reset = 0; Q1 = 0; Q2 = 0;
    drv(1, 5'd3, 32'h55, 32'h10, 0, 0);
    cyc(); cyc();
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);

    // First push after reset release, one-cycle latency to WE.
    reset = 1;
    drv(1, 5'd5, 32'h1234, 32'h3000, 0, 0);
    cyc();
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk("first_WE", {31'd0, WE}, 32'd1);
    chk("first_A3", {27'd0, A3}, 32'd5);
    chk("first_WD", WD, 32'h1234);
    cyc();
    chk("first_drained", {29'd0, count}, 32'd0);

    // Fill under hold, 5th push waits for space.
    for (int i = 1; i <= 4; i++) begin
      drv(1, 5'(i), 32'h11 * i, 32'h4000 + 4 * i, 1, 0);
      cyc();
    end
    drv(1, 5'd6, 32'h66, 32'h4020, 1, 0);
    #1;
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    cyc(); cyc();
    hold = 0;
    cyc(); cyc();
    drv(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc();

    // Bypass returns youngest match.
    drv(1, 5'd8, 32'hA, 32'h5000, 1, 0); cyc();
    drv(1, 5'd8, 32'hB, 32'h5004, 1, 0); cyc();
    drv(1, 5'd9, 32'hC, 32'h5008, 1, 0); cyc();
    drv(0, 0, 0, 0, 1, 0); Q1 = 8; Q2 = 0;
    #1;
    chk("byp_hit1", {31'd0, hit1}, 32'd1);
    chk("byp_data1", hit1_data, 32'hB);
    chk("byp_hit2", {31'd0, hit2}, 32'd0);
    chk("byp_data2", hit2_data, 32'd0);
    hold = 0;
    for (int i = 0; i < 4; i++) cyc();

    // $0 write consumed and dropped.
    drv(1, 5'd0, 32'hFFFF, 32'h6000, 0, 0);
    #1;
    chk("zero_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk("zero_count", {29'd0, count}, 32'd0);
    chk("zero_WE", {31'd0, WE}, 32'd0);
    cyc();

    // Streaming push/pop across pointer wrap.
    w0 = wcount;
    for (int i = 0; i < 10; i++) begin
      drv(1, 5'(i % 31 + 1), $urandom, 32'h7000 + 4 * i, 0, 0);
      cyc();
    end
    drv(0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    chk("stream_writes", wcount - w0, 32'd10);

    // Flush with concurrent push, then async reset mid-queue.
    for (int i = 0; i < 3; i++) begin
      drv(1, 5'(i + 10), 32'h100 + i, 32'h8000, 1, 0);
      cyc();
    end
    drv(1, 5'd20, 32'hDEAD, 32'h8010, 1, 1);
    cyc();
    drv(0, 0, 0, 0, 1, 0);
    #1;
    chk("flush_count", {29'd0, count}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      drv(1, 5'(i + 12), 32'h200 + i, 32'h9000, 0, 0);
      cyc();
    end
    drv(0, 0, 0, 0, 0, 0);
    #1;
    reset = 0;
    #1;
    chk("arst_WE", {31'd0, WE}, 32'd0);
    chk("arst_count", {29'd0, count}, 32'd0);
    cyc();
    reset = 1;
    cyc();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drv($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom, $urandom,
          $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
      Q1 = 5'($urandom_range(0, 7));
      Q2 = 5'($urandom_range(0, 7));
      reset = ($urandom_range(0, 99) != 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/grf_write_buffer.md
# grf_write_buffer

Write-back buffer sitting in front of the GRF write port (A3/WD/WE/PC). Producers (ALU result, load data, multiply/divide completion) push register-write requests through a valid/ready handshake. The block queues them in order and issues at most one GRF write per cycle. It also gives the decode/read side a bypass lookup, so reads see the youngest pending value before it is committed.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low (0 = reset asserted)
- in_valid  input  1  producer has a write request
- in_ready  output  1  buffer accepts the request this cycle
- in_A3  input  5  destination register
- in_WD  input  32  write data
- in_PC  input  32  PC of the producing instruction
- hold  input  1  GRF port unavailable; suppress drain this cycle
- flush  input  1  synchronous discard of all queued entries
- A3  output  5  GRF write address (head entry)
- WD  output  32  GRF write data (head entry)
- PC  output  32  PC of head entry
- WE  output  1  GRF write enable
- Q1, Q2  input  5 each  bypass lookup addresses (driven with GRF A1/A2)
- hit1, hit2  output  1 each  a pending write to Q1/Q2 exists
- hit1_data, hit2_data  output  32 each  data of the youngest pending write to Q1/Q2
- count  output  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular FIFO with head and tail pointers of $clog2(DEPTH) bits plus wrap bit; pointers wrap modulo DEPTH.
- Accept: in_valid & in_ready at posedge.
  - in_A3 != 0: enqueue at tail.
  - in_A3 == 0: request is consumed and discarded; no entry, count unchanged.
- in_ready = !full & !flush & reset. There is no same-cycle pass-through when full, even if a drain occurs that cycle.
- Drain: WE = !empty & !hold. A3/WD/PC show the head entry whenever the buffer is non-empty. When empty they are 0.
- At a posedge with WE=1, the head is popped. The GRF writes the same edge.
- Simultaneous push and pop: both take effect and count is unchanged. Legal at any non-full occupancy.
- flush=1: at the next posedge all entries are invalidated, count=0, and the push that cycle is ignored. WE is still asserted combinationally that cycle if non-empty. The GRF write at that edge is allowed.
- Bypass: hitN=1 iff QN != 0 and some valid entry has matching A3. hitN_data comes from the youngest match, closest to tail. On miss, or QN==0, hitN=0 and hitN_data=0. Purely combinational on current contents. An entry being pushed this cycle is not visible.
- Reset asserted (low): pointers and count clear immediately, all entries invalid. Outputs are WE=0, A3=0, WD=0, PC=0, hit*=0, hit*_data=0, in_ready=0, count=0. Reset mid-operation loses all queued writes.

## Timing
- Accept-to-WE latency: 1 cycle. An entry pushed at edge N is on A3/WD/WE during cycle N+1 and commits at edge N+1 if hold=0.
- Throughput: one push and one drain per cycle.
- hold stalls the head indefinitely. Entries are never reordered or dropped by hold.
- Reset deassertion takes effect asynchronously. The first accept is possible at the first posedge with reset=1.

## Configuration
- GRF_WB_TRACE_EN defined: at every posedge with WE=1, prints `$display("@%h: $%d <= %h", PC, A3, WD)` in the same format as the GRF trace. The GRF-side print must then be disabled to avoid duplicates.
- Not defined: no simulation output. Logic is identical.

## Test plan
- Reset: hold reset=0 with in_valid=1 -> in_ready=0, WE=0, count=0. Release, push $5<=0x1234 PC=0x3000 -> next cycle WE=1, A3=5, WD=0x1234. The following cycle count=0.
- Fill with hold=1: push $1..$4 with data 0x11..0x44 -> count=4, in_ready=0. A 5th push is held until one cycle after hold drops. Drain order is $1,$2,$3,$4.
- Bypass youngest: queue $8<=0xA, $8<=0xB, $9<=0xC with hold=1, Q1=8, Q2=0 -> hit1=1, hit1_data=0xB, hit2=0, hit2_data=0.
- $0 writes: push in_A3=0, WD=0xFFFF -> accepted (in_ready=1), count stays 0, WE never asserts.
- Wrap plus simultaneous push/pop: stream 10 consecutive pushes with hold=0, DEPTH=4 -> count stays 1 after the first, and 10 ordered GRF writes occur.
- Flush and async reset mid-queue: 3 entries queued, assert flush with in_valid=1 -> count=0 next edge, pushed entry absent. Refill 2 entries, pull reset low between edges -> WE=0 and count=0 immediately.
